// File: rtl/spi_ram_master_if.sv
// Request/response bundle between on-chip logic and the SPI RAM sequencer.
// The master side issues byte read/write requests; the slave side serves them.
interface spi_ram_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       done;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output done
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI host sequencer: expands byte read/write requests into two
// 10-bit command frames for the SPI slave + RAM subsystem.
module spi_ram_master #(
  parameter int LEAD_CYCLES  = 1,
  parameter int GAP_CYCLES   = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_master_if.slave   bus,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int MAX_LG =
    (LEAD_CYCLES > GAP_CYCLES) ? LEAD_CYCLES : GAP_CYCLES;
  localparam int MAX_P =
    (MAX_LG > READ_LATENCY) ? MAX_LG : READ_LATENCY;
  localparam int WW = $clog2(MAX_P) + 1;

  localparam logic [WW-1:0] LEAD_LD = WW'(LEAD_CYCLES - 1);
  localparam logic [WW-1:0] GAP_LD  = WW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] RL_LD   = WW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD, SHIFT, RD_WAIT, RD_CAP, GAP
  } state_e;

  state_e        state_q, state_d;
  logic          second_q, second_d;
  logic          write_q, write_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [3:0]    bit_q, bit_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    cap_q, cap_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          done_q, done_d;
  logic [9:0]    frame;

  // cmd[1] = read, cmd[0] = second frame; read-data payload is zero
  always_comb begin
    frame = {~write_q, second_q, addr_q};
    if (second_q) begin
      frame[7:0] = write_q ? wdata_q : 8'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    second_d    = second_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bit_d       = bit_q;
    wait_d      = wait_q;
    cap_d       = cap_q;
    ss_n_d      = ss_n_q;
    mosi_d      = 1'b0;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_d  = LEAD;
          second_d = 1'b0;
          write_d  = bus.req_write;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          wait_d   = LEAD_LD;
          ss_n_d   = 1'b0;
          ready_d  = 1'b0;
        end
      end
      LEAD: begin
        if (wait_q == '0) begin
          state_d = SHIFT;
          bit_d   = 4'd9;
          mosi_d  = frame[9];
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      SHIFT: begin
        if (bit_q == 4'd0) begin
          if (second_q && !write_q) begin
            if (READ_LATENCY == 0) begin
              state_d = RD_CAP;
              bit_d   = 4'd7;
            end else begin
              state_d = RD_WAIT;
              wait_d  = RL_LD;
            end
          end else begin
            state_d = GAP;
            wait_d  = GAP_LD;
            ss_n_d  = 1'b1;
          end
        end else begin
          bit_d  = bit_q - 4'd1;
          mosi_d = frame[bit_q - 4'd1];
        end
      end
      RD_WAIT: begin
        if (wait_q == '0) begin
          state_d = RD_CAP;
          bit_d   = 4'd7;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      RD_CAP: begin
        cap_d = {cap_q[6:0], MISO};
        if (bit_q == 4'd0) begin
          state_d = GAP;
          wait_d  = GAP_LD;
          ss_n_d  = 1'b1;
        end else begin
          bit_d = bit_q - 4'd1;
        end
      end
      GAP: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else if (!second_q) begin
          state_d  = LEAD;
          second_d = 1'b1;
          wait_d   = LEAD_LD;
          ss_n_d   = 1'b0;
        end else begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          done_d      = 1'b1;
          rsp_valid_d = ~write_q;
          if (!write_q) begin
            rdata_d = cap_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      second_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      bit_q       <= 4'd0;
      wait_q      <= '0;
      cap_q       <= 8'h00;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      second_q    <= second_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      cap_q       <= cap_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
    end
  end

  assign SS_n          = ss_n_q;
  assign MOSI          = mosi_q;
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master with default timing parameters.
// Cycle c means "just after the c-th rising edge following acceptance".
module tb_spi_ram_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SS_n;
  logic MOSI;
  logic MISO = 1'b0;

  spi_ram_master_if bus ();

  spi_ram_master dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int errors = 0;

  logic [9:0]  r_f1, r_f2;
  logic [63:0] r_ss;
  logic        r_mosi_bad;
  int          r_done_cyc, r_rsp_cyc, r_rsp_cnt;
  logic        r_done_after, r_rsp_after;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_ss(input int last_low);
    logic [63:0] v;
    for (int c = 0; c < 64; c++)
      v[c] = !((c <= 10) || (c >= 12 && c <= last_low));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then scramble request inputs after acceptance.
  // mb is the byte a MISO model returns during capture cycles 25..32.
  task automatic run_txn(input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] mb);
    bit seen;
    seen = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = ~a;
    bus.req_wdata = ~d;
    r_f1 = '0; r_f2 = '0; r_ss = '1; r_mosi_bad = 1'b0;
    r_done_cyc = 0; r_rsp_cyc = 0; r_rsp_cnt = 0;
    r_ss[0] = SS_n;
    for (int c = 1; c <= 60 && !seen; c++) begin
      tick();
      MISO = (c >= 25 && c <= 32) ? mb[32 - c] : 1'b0;
      r_ss[c] = SS_n;
      if (c <= 10) r_f1 = {r_f1[8:0], MOSI};
      else if (c >= 13 && c <= 22) r_f2 = {r_f2[8:0], MOSI};
      else if (MOSI) r_mosi_bad = 1'b1;
      if (bus.rsp_valid) begin
        r_rsp_cnt++;
        r_rsp_cyc = c;
      end
      if (bus.done) begin
        r_done_cyc = c;
        seen = 1'b1;
      end
    end
    tick();
    MISO = 1'b0;
    r_done_after = bus.done;
    r_rsp_after  = bus.rsp_valid;
  endtask

  int dcnt, d1, d2;
  logic ss24, rdy24, ss25, rdy25;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ss_n", 64'(SS_n), 64'd1);
    check("rst_mosi", 64'(MOSI), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rdata", 64'(bus.rsp_rdata), 64'h00);
    check("rst_done", 64'(bus.done), 64'd0);

    // write 0x12 <- 0x5A
    run_txn(1'b1, 8'h12, 8'h5A, 8'h00);
    check("wr_f1", 64'(r_f1), 64'b00_0001_0010);
    check("wr_f2", 64'(r_f2), 64'b01_0101_1010);
    check("wr_ss", r_ss, exp_ss(22));
    check("wr_mosi_idle", 64'(r_mosi_bad), 64'd0);
    check("wr_done_cyc", 64'(r_done_cyc), 64'd24);
    check("wr_rsp_cnt", 64'(r_rsp_cnt), 64'd0);
    check("wr_done_width", 64'(r_done_after), 64'd0);

    // read 0x12, slave returns 0xA5
    run_txn(1'b0, 8'h12, 8'h33, 8'hA5);
    check("rd_f1", 64'(r_f1), 64'b10_0001_0010);
    check("rd_f2", 64'(r_f2), 64'b11_0000_0000);
    check("rd_ss", r_ss, exp_ss(32));
    check("rd_mosi_idle", 64'(r_mosi_bad), 64'd0);
    check("rd_done_cyc", 64'(r_done_cyc), 64'd34);
    check("rd_rsp_cyc", 64'(r_rsp_cyc), 64'd34);
    check("rd_rsp_cnt", 64'(r_rsp_cnt), 64'd1);
    check("rd_rdata", 64'(bus.rsp_rdata), 64'hA5);

    // req_valid held through two writes
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h34;
    bus.req_wdata = 8'h01;
    tick();
    dcnt = 0; d1 = 0; d2 = 0;
    ss24 = 1'b0; rdy24 = 1'b0; ss25 = 1'b1; rdy25 = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) d1 = c; else d2 = c;
      end
      if (c == 24) begin
        ss24 = SS_n;
        rdy24 = bus.req_ready;
      end
      if (c == 25) begin
        ss25 = SS_n;
        rdy25 = bus.req_ready;
        bus.req_valid = 1'b0;
      end
    end
    check("b2b_done_cnt", 64'(dcnt), 64'd2);
    check("b2b_done1", 64'(d1), 64'd24);
    check("b2b_done2", 64'(d2), 64'd49);
    check("b2b_ss_gap", 64'(ss24), 64'd1);
    check("b2b_ready_done", 64'(rdy24), 64'd1);
    check("b2b_ss_second", 64'(ss25), 64'd0);
    check("b2b_ready_busy", 64'(rdy25), 64'd0);
    check("b2b_rdata_kept", 64'(bus.rsp_rdata), 64'hA5);

    // reset during 5th bit of a read's second frame
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h77;
    tick();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 17; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ss_n", 64'(SS_n), 64'd1);
    check("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_mid_rdata", 64'(bus.rsp_rdata), 64'h00);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.done || bus.rsp_valid) dcnt++;
    end
    check("rst_mid_no_pulse", 64'(dcnt), 64'd0);
    run_txn(1'b1, 8'h9C, 8'h3E, 8'h00);
    check("post_rst_f1", 64'(r_f1), 64'b00_1001_1100);
    check("post_rst_f2", 64'(r_f2), 64'b01_0011_1110);
    check("post_rst_done", 64'(r_done_cyc), 64'd24);

    // all-ones then all-zeros read data
    run_txn(1'b0, 8'hFE, 8'h00, 8'hFF);
    check("rd_ff_rdata", 64'(bus.rsp_rdata), 64'hFF);
    check("rd_ff_done", 64'(r_done_cyc), 64'd34);
    check("rd_ff_rsp_width", 64'(r_rsp_after), 64'd0);
    check("rd_ff_f1", 64'(r_f1), 64'b10_1111_1110);
    run_txn(1'b0, 8'h01, 8'h00, 8'h00);
    check("rd_00_rdata", 64'(bus.rsp_rdata), 64'h00);
    check("rd_00_rsp_cyc", 64'(r_rsp_cyc), 64'd34);
    check("rd_00_rsp_width", 64'(r_rsp_after), 64'd0);

    $display("%0d/%0d checks passed", total - errors, total);
    $finish;
  end
endmodule
